// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
// Owns the HI/LO registers. A one-cycle start pulse launches an operation.
// The result is computed into a pending register on the start edge and
// committed to HI/LO when a down-counter runs out. The counter models the
// multi-cycle latency.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (ops 1000-1011). These accumulate onto {hi,lo}.
//
// Ports:
//   clk      in   pipeline clock, all state on rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   one-cycle pulse when an md-family write op is in EX
//   op[3:0]  in   operation, sampled with start
//   a[31:0]  in   forwarded rs operand
//   b[31:0]  in   forwarded rt operand
//   busy     out  high while a multi-cycle op is in flight (to hazard unit)
//   hi[31:0] out  HI register
//   lo[31:0] out  LO register
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b1000;
  localparam logic [3:0] OP_MADDU = 4'b1001;
  localparam logic [3:0] OP_MSUB  = 4'b1010;
  localparam logic [3:0] OP_MSUBU = 4'b1011;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      phi_q, phi_d;
  logic [31:0]      plo_q, plo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  state_e           state;
  logic             commit_ok;

  // Datapath, evaluated on the live operands so the result is ready on the start edge.
  logic signed [63:0] a_sx, b_sx;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        b_safe;
  logic               div_ovf;
  logic signed [31:0] quo_raw, rem_raw;
  logic [31:0]        quo_s, rem_s, quo_u, rem_u;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, a} * {32'b0, b};

  // A zero divisor is replaced so the divider never sees it. That result is
  // never committed anyway.
  assign b_safe  = (b == 32'd0) ? 32'd1 : b;
  // INT_MIN / -1 overflows a 32-bit signed divide, so it is pinned explicitly.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign quo_raw = $signed(a) / $signed(b_safe);
  assign rem_raw = $signed(a) % $signed(b_safe);
  assign quo_s   = div_ovf ? 32'h8000_0000 : quo_raw;
  assign rem_s   = div_ovf ? 32'd0 : rem_raw;
  assign quo_u   = a / b_safe;
  assign rem_u   = a % b_safe;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q};
`endif

  assign state = (cnt_q != '0) ? RUN : IDLE;

  // A divide by zero still runs its full latency but leaves HI/LO untouched.
  assign commit_ok = !(((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'd0));

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    b_d   = b_q;
    phi_d = phi_q;
    plo_d = plo_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    case (state)
      RUN: begin
        // start is ignored here; only the countdown advances.
        cnt_d = cnt_q - 1'b1;
        if ((cnt_q == CNT_W'(1)) && commit_ok) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end
      default: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              op_d  = op;
              b_d   = b;
              {phi_d, plo_d} = (op == OP_MULT) ? prod_s : prod_u;
              cnt_d = CNT_W'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
              op_d  = op;
              b_d   = b;
              {phi_d, plo_d} = (op == OP_DIV) ? {rem_s, quo_s} : {rem_u, quo_u};
              cnt_d = CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              op_d  = op;
              b_d   = b;
              {phi_d, plo_d} = acc + ((op == OP_MADD) ? prod_s : prod_u);
              cnt_d = CNT_W'(MULT_CYCLES);
            end
            OP_MSUB, OP_MSUBU: begin
              op_d  = op;
              b_d   = b;
              {phi_d, plo_d} = acc - ((op == OP_MSUB) ? prod_s : prod_u);
              cnt_d = CNT_W'(MULT_CYCLES);
            end
`endif
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      op_q  <= '0;
      b_q   <= '0;
      phi_q <= '0;
      plo_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      b_q   <= b_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Takes forwarded rs/rt operands together with a one-cycle start pulse, and owns the HI/LO registers.
- Drives busy back to the hazard unit. The hazard unit stalls any D-stage md-family instruction (mult/div/mfhi/mflo/mthi/mtlo) while start|busy.
- Multi-cycle latency is modelled with a down-counter; operands are latched at start.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd family), must be >=1.
- DIV_CYCLES, 10: busy cycles for div/divu, must be >=1.

Ports:
- clk  input  1  pipeline clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse from E stage when an md-family write op is in EX.
- op  input  4  operation, sampled with start.
- a  input  32  forwarded rs operand (frse-selected).
- b  input  32  forwarded rt operand (frte-selected).
- busy  output  1  high while a multi-cycle op is in flight; feeds hazard unit.
- hi  output  32  HI register, read by mfhi in EX.
- lo  output  32  LO register, read by mflo in EX.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: hi=0, lo=0, busy=0, counter=0, latched operands=0, pending result=0.
- op encoding:
  - 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MTHI, 0101 MTLO.
  - 1000-1011 reserved for the optional feature.
  - Any other value with start is a no-op: no state change, busy stays 0.
- States: IDLE (cnt==0) and RUN (cnt!=0). busy = (cnt!=0), driven from the register, not from start.
- IDLE, start=1, multiply/divide op at edge T:
  - Latch op, a and b.
  - Compute the 64-bit result into an internal pending register {phi,plo}.
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
  - busy is high for exactly N cycles after edge T.
- RUN: cnt decrements each edge. On the edge where cnt goes 1->0, hi<=phi and lo<=plo. New hi/lo are visible in the first cycle busy is low.
- MTHI/MTLO with start in IDLE: hi<=a (or lo<=a) on the same edge. Single cycle, busy stays 0.
- start while busy: ignored completely, no op change and no counter reload. The hazard unit prevents this; it must still be benign.
- Arithmetic:
  - MULT: {hi,lo} = signed(a)*signed(b), 64-bit. MULTU: unsigned.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b==0, DIV or DIVU): busy runs the full DIV_CYCLES; hi/lo keep their previous values.
- reset_n asserted mid-operation: counter clears and busy drops immediately (async); the pending result is discarded.
- hi/lo change only on completion edges, MTHI/MTLO edges, or reset.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Ops 1000 MADD, 1001 MADDU, 1010 MSUB, 1011 MSUBU are enabled.
  - Pending result = {hi,lo} ± product, signed/unsigned as for MULT/MULTU, with 64-bit wrap-around.
  - Latency is MULT_CYCLES.
  - The {hi,lo} used as the accumulator is the value at the start edge.
- Not defined: ops 1000-1011 are no-ops, identical to other undefined encodings.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; when busy falls hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (busy never rises) -> DIV with b=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- MULT started, second start (DIVU) pulsed at busy cycle 2 -> ignored; busy still falls 5 cycles after the first start; result is the MULT result.
- MULT started, reset_n pulled low at busy cycle 3 -> busy=0, hi=lo=0 immediately, no later update.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> after 5 cycles hi=1, lo=0. Without the macro, the same op leaves hi/lo unchanged and busy=0.
